// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - edge/level interrupt capture, masking and priority gating in front of CP0
// Bridge-visible PEND/MASK/MODE/STAT window; VEC blocks the serviced source and everything below it.
module irq_sequencer #(
   parameter int          NIRQ = 6,
   parameter logic [31:0] BASE = 32'h0000_7F40
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NIRQ-1:0] IrqIn,
   input  logic [31:0]     Addr,
   input  logic [31:0]     WData,
   input  logic            WE,
   output logic [31:0]     RData,
   output logic [NIRQ-1:0] HWInt,
   input  logic            IntTaken,
   input  logic            EXLClr,
   output logic            InService
);

   localparam int VW = 3;

   typedef enum logic {S_IDLE, S_SERVICE} state_t;

   state_t          r_state, w_state_nxt;
   logic [VW-1:0]   r_vec, w_vec_nxt;
   logic [NIRQ-1:0] r_pend, r_mask, r_mode, r_prev;

   logic            w_hit;
   logic [1:0]      w_off;
   logic            w_wr_pend, w_wr_mask, w_wr_mode;
   logic [NIRQ-1:0] w_elig, w_visible, w_ack, w_w1c, w_rise;
   logic [VW-1:0]   w_top;
   logic            w_take;
   logic            w_unused;

   assign w_hit     = (Addr[31:4] == BASE[31:4]);
   assign w_off     = Addr[3:2];
   assign w_wr_pend = WE & w_hit & (w_off == 2'd0);
   assign w_wr_mask = WE & w_hit & (w_off == 2'd1);
   assign w_wr_mode = WE & w_hit & (w_off == 2'd2);
   assign w_unused  = ^{Addr[1:0], WData[31:NIRQ]};

   assign w_elig = r_pend & r_mask;
   assign w_w1c  = w_wr_pend ? WData[NIRQ-1:0] : '0;
   assign w_rise = IrqIn & ~r_prev;

   // While servicing, only sources strictly above VEC may reach CP0.
   always_comb begin
      w_visible = '1;
      if (r_state == S_SERVICE) begin
         for (int i = 0; i < NIRQ; i++) begin
            w_visible[i] = (VW'(i) > r_vec);
         end
      end
   end

   assign HWInt     = w_elig & w_visible;
   assign InService = (r_state == S_SERVICE);

   always_comb begin
      w_top = '0;
      for (int i = 0; i < NIRQ; i++) begin
         if (HWInt[i]) w_top = VW'(i);
      end
   end

   assign w_take = IntTaken & (|HWInt);

   always_comb begin
      w_ack = '0;
      for (int i = 0; i < NIRQ; i++) begin
         w_ack[i] = w_take & (w_top == VW'(i)) & r_mode[i];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      case (r_state)
         S_IDLE: begin
            if (w_take) begin
               w_state_nxt = S_SERVICE;
               w_vec_nxt   = w_top;
            end
         end
         S_SERVICE: begin
            // A new take overrides eret in the same cycle; there is no nesting stack.
            if (w_take) begin
               w_vec_nxt = w_top;
            end else if (EXLClr) begin
               w_state_nxt = S_IDLE;
               w_vec_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_vec_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_vec   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= '0;
         r_mask <= '0;
         r_mode <= '0;
         r_prev <= '0;
      end else begin
         r_prev <= IrqIn;
         if (w_wr_mask) r_mask <= WData[NIRQ-1:0];
         if (w_wr_mode) r_mode <= WData[NIRQ-1:0];
         for (int i = 0; i < NIRQ; i++) begin
            if (r_mode[i]) begin
               if (w_rise[i])                 r_pend[i] <= 1'b1;
               else if (w_w1c[i] | w_ack[i])  r_pend[i] <= 1'b0;
            end else begin
               r_pend[i] <= IrqIn[i];
            end
         end
      end
   end

   always_comb begin
      RData = '0;
      if (w_hit) begin
         case (w_off)
            2'd0: RData[NIRQ-1:0] = r_pend;
            2'd1: RData[NIRQ-1:0] = r_mask;
            2'd2: RData[NIRQ-1:0] = r_mode;
            default: begin
               RData[31]     = InService;
               RData[VW-1:0] = r_vec;
            end
         endcase
      end
   end

endmodule
